// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU use shift-add (LSB first), DIV/DIVU use restoring division
// (MSB first). Every operation takes exactly 33 cycles from the start edge
// to the done pulse, including divide-by-zero.
//
// Handshake: start is accepted only on an edge where the unit is idle
// (busy=0). busy stays high from the edge after acceptance until the result
// edge. done is a one-cycle pulse in the cycle that hi/lo carry the new
// result. A start in the done cycle is accepted. A start, MTHI or MTLO seen
// while busy is dropped.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] hilo_write_data,
  input  logic                  write_hi,
  input  logic                  write_lo,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              is_div_q;
  logic              sign_a_q, sign_b_q, div_zero_q;
  logic [W-1:0]      a_q, b_q;
  logic [2*W-1:0]    work_q;
  logic [CW-1:0]     count_q;
  logic              done_q;
  logic [W-1:0]      hi_q, lo_q;

  // Start-time operand conditioning: signed ops work on magnitudes.
  logic              start_sign_a, start_sign_b;
  logic [W-1:0]      start_abs_a, start_abs_b;

  // One iteration of each algorithm.
  logic [CW-2:0]     idx;
  logic [W-1:0]      mul_addend;
  logic [W:0]        mul_sum;
  logic [2*W-1:0]    mul_next;
  logic [W-1:0]      a_shift;
  logic [W:0]        div_rem_shift;
  logic              div_ge;
  logic [W-1:0]      div_rem_next;
  logic [2*W-1:0]    div_next;

  // Final sign-corrected results.
  logic [2*W-1:0]    prod_res;
  logic [W-1:0]      quot, rem;
  logic [W-1:0]      res_hi, res_lo;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next-state logic: 32 RUN edges, then one FINISH edge that writes HI/LO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == CW'(W - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes and sign flags captured with start (op[0]=1 is unsigned).
  always_comb begin
    start_sign_a = ~op[0] & operand_a[W-1];
    start_sign_b = ~op[0] & operand_b[W-1];
    start_abs_a  = start_sign_a ? -operand_a : operand_a;
    start_abs_b  = start_sign_b ? -operand_b : operand_b;
  end

  // Single iteration datapath for both shift-add and restoring division.
  always_comb begin
    idx           = count_q[CW-2:0];
    mul_addend    = b_q[idx] ? a_q : '0;
    mul_sum       = {1'b0, work_q[2*W-1:W]} + {1'b0, mul_addend};
    mul_next      = {mul_sum, work_q[W-1:1]};
    a_shift       = a_q << idx;
    div_rem_shift = {work_q[2*W-1:W], a_shift[W-1]};
    div_ge        = (div_rem_shift >= {1'b0, b_q});
    div_rem_next  = div_ge ? (div_rem_shift[W-1:0] - b_q) : div_rem_shift[W-1:0];
    div_next      = {div_rem_next, work_q[W-2:0], div_ge};
  end

  // Sign correction; divide by zero returns the raw dividend and all-ones.
  always_comb begin
    prod_res = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
    quot     = work_q[W-1:0];
    rem      = work_q[2*W-1:W];
    res_hi   = prod_res[2*W-1:W];
    res_lo   = prod_res[W-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = sign_a_q ? -a_q : a_q;
        res_lo = '1;
      end else begin
        res_hi = sign_a_q ? -rem : rem;
        res_lo = (sign_a_q ^ sign_b_q) ? -quot : quot;
      end
    end
  end

  // State, operand latches, work register and the architectural HI/LO pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      count_q    <= '0;
      work_q     <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FINISH);
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q   <= op[1];
            sign_a_q   <= start_sign_a;
            sign_b_q   <= start_sign_b;
            a_q        <= start_abs_a;
            b_q        <= start_abs_b;
            div_zero_q <= (operand_b == '0);
            work_q     <= '0;
            count_q    <= '0;
          end else begin
            if (write_hi) hi_q <= hilo_write_data;
            if (write_lo) lo_q <= hilo_write_data;
          end
        end
        RUN: begin
          work_q  <= is_div_q ? div_next : mul_next;
          count_q <= count_q + 1'b1;
        end
        FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit: directed scenarios plus random operations,
// with a scoreboard queue filled at issue time and drained by a done monitor.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, hilo_write_data;
  logic        write_hi, write_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_write_data(hilo_write_data), .write_hi(write_hi), .write_lo(write_lo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Clock and cycle counter (cyc = index of the most recent rising edge).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;
  logic [63:0] mon_exp;
  int          mon_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      2'd1: begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_lat = lat_q.pop_front();
        check("result_hilo", {hi, lo}, mon_exp);
        check("done_latency", 64'(cyc), 64'(mon_lat));
        cur_hi = mon_exp[63:32];
        cur_lo = mon_exp[31:0];
      end
    end
  end

  // Driver: called at a negedge; start is sampled on the following edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic whi, input logic wlo, input logic [31:0] d);
    start = 1'b1; op = o; operand_a = x; operand_b = y;
    write_hi = whi; write_lo = wlo; hilo_write_data = d;
    exp_q.push_back(model(o, x, y));
    lat_q.push_back(cyc + 1 + 33);
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
  endtask

  // Waits (bounded) for done, checking busy and HI/LO hold while running.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      check("busy_run", 64'(busy), 64'd1);
      check("hold_hi", 64'(hi), 64'(cur_hi));
      check("hold_lo", 64'(lo), 64'(cur_lo));
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done within 40 cycles (cycle %0d)", cyc);
    end else begin
      check("busy_done", 64'(busy), 64'd0);
    end
  endtask

  // Idle MTHI/MTLO write; called at a negedge.
  task automatic mt(input logic whi, input logic wlo, input logic [31:0] d);
    write_hi = whi; write_lo = wlo; hilo_write_data = d;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0;
    if (whi) cur_hi = d;
    if (wlo) cur_lo = d;
    check("mt_hi", 64'(hi), 64'(cur_hi));
    check("mt_lo", 64'(lo), 64'(cur_lo));
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    hilo_write_data = '0; write_hi = 1'b0; write_lo = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed multiply, then MULTU/DIV/DIVU back to back.
    issue(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, '0); wait_done();
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0); wait_done();
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0); wait_done();
    issue(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, '0); wait_done();
    // Divide by zero and the signed overflow case.
    issue(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, '0); wait_done();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0); wait_done();
    issue(2'd2, 32'hFFFFFF9C, 32'd0, 1'b0, 1'b0, '0); wait_done();
    @(negedge clk);

    // Start and MTHI while busy are ignored; new start in the done cycle.
    issue(2'd0, 32'd5, 32'd6, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; operand_a = 32'd9; operand_b = 32'd3;
    write_hi = 1'b1; hilo_write_data = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0;
    wait_done();
    issue(2'd3, 32'd9, 32'd3, 1'b0, 1'b0, '0); wait_done();
    repeat (2) @(negedge clk);

    // Idle MTHI/MTLO, then start with MTLO in the same cycle.
    mt(1'b1, 1'b0, 32'h12345678);
    mt(1'b0, 1'b1, 32'h9ABCDEF0);
    mt(1'b1, 1'b1, 32'h0BADF00D);
    issue(2'd1, 32'd3, 32'd4, 1'b0, 1'b1, 32'h55555555); wait_done();
    @(negedge clk);

    // Reset mid-operation aborts with no done and clears HI/LO.
    issue(2'd2, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); lat_q.delete();
    cur_hi = '0; cur_lo = '0;
    seen = done_seen;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'(seen));
    issue(2'd0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, '0); wait_done();

    // Random operations with random gaps and idle HI/LO writes.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      issue(ro, pick(), pick(), 1'b0, 1'b0, '0);
      wait_done();
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if ($urandom_range(0, 2) == 0)
          mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, plus MTHI and MTLO.
- Sits directly downstream of the register file. operand_a is driven from read_data_1 (rs); operand_b is driven from read_data_2 (rt).
- Holds the architectural HI/LO pair. hi/lo feed the writeback mux for MFHI/MFLO, which returns them to the register file write_data path.
- Uses a busy/done handshake so the controller stalls on HI/LO hazards.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on posedge.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operand_a  input  32  rs value (multiplicand / dividend).
- operand_b  input  32  rt value (multiplier / divisor).
- hilo_write_data  input  32  MTHI/MTLO data.
- write_hi  input  1  MTHI strobe.
- write_lo  input  1  MTLO strobe.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (edge with reset=1):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Applies from any state. A reset during RUN or FINISH aborts the operation with no HI/LO update.
- State machine: IDLE, RUN, FINISH. busy=1 iff state is not IDLE. Outputs are registered.
- Handshake, IDLE + start=1 at edge t0:
  - Latch op, absolute-value operands (signed ops only), sign flags and the divide-by-zero flag.
  - Clear the 64-bit work register and set counter=0. Go to RUN.
- RUN, edges t1..t32: one iteration per edge, counter increments.
  - MUL: shift-add, one multiplier bit per cycle (LSB first).
  - DIV: restoring shift-subtract, one quotient bit per cycle (MSB first).
  - At the edge where counter reaches 31, go to FINISH.
- FINISH, edge t33:
  - Apply sign correction and write hi/lo. done=1, busy=0, state=IDLE.
  - done deasserts at t34 unless a new operation finishes then.
  - Fixed latency: done is high exactly 33 cycles after the start edge, for every op and every operand value.
- Back-to-back: start may be asserted in the done cycle; it is accepted at that edge.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. For MULT, negate the 64-bit magnitude if sign_a XOR sign_b.
  - DIV/DIVU: lo=quotient, hi=remainder. DIV: quotient negative iff sign_a XOR sign_b; remainder takes the sign of the dividend (truncation toward zero).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (operand_b=0, DIV or DIVU): hi=operand_a unmodified, lo=0xFFFFFFFF. Same latency, no exception.
- Ignored inputs:
  - start while busy=1: ignored, no queuing.
  - write_hi/write_lo while busy=1: ignored.
- MTHI/MTLO in IDLE: write_hi=1 sets hi=hilo_write_data at that edge; write_lo likewise sets lo. Both strobes high: both registers take the same data.
- Simultaneous start and write_hi/write_lo in IDLE: start wins, the writes are dropped.
- hi/lo hold their values through RUN and change only at FINISH, reset, or MTHI/MTLO. MFHI issued while busy therefore reads the previous result; stalling on busy is the controller's job.
- Edge relation to the register file: this block updates on posedge and the register file writes on negedge. A result written back in a given cycle is readable as an operand in the next cycle.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> done at t0+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high t0+1..t0+33 exclusive of done cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIVU 7/2 -> lo=3, hi=1.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF at t0+33. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT 5*6. At t0+5, assert start (DIVU 9/3) and write_hi=1 with data 0xDEAD -> both ignored; result hi=0, lo=30. A new start in the done cycle is accepted and completes 33 cycles later.
- Idle MTHI 0x12345678 and MTLO 0x9ABCDEF0 in consecutive cycles -> hi/lo updated at their edges. Start with write_lo=1 in the same cycle -> lo unchanged until the operation result is written.
- Start DIV, assert reset at t0+10 -> next edge busy=0, done=0, hi=lo=0. No done pulse follows. A new start after reset completes normally.
